// File: rtl/dpm_pkg.sv
// ============================================================================
// Module   : dpm_pkg
// Purpose  : Shared size codes, sequencer state type and beat helpers for the
//            DPM data-path operand sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dpm_pkg;

  // Operand size codes; byte count of an operand is 2**code.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_WORD = 2'd1;
  localparam logic [1:0] SZ_LONG = 2'd2;
  localparam logic [1:0] SZ_QUAD = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dseq_state_t;

  // Per-beat size: an operand never moves more than one bus width per beat.
  function automatic logic [1:0] clamp_size(input logic [1:0] code,
                                            input logic [1:0] bus_lg);
    return (code > bus_lg) ? bus_lg : code;
  endfunction

  // Index of the final beat (beat count minus one) for an operand size.
  function automatic logic [2:0] last_beat_idx(input logic [1:0] code,
                                               input logic [1:0] bus_lg);
    logic [2:0] idx;
    idx = 3'd0;
    if (code > bus_lg) begin
      idx = (3'd1 << (code - bus_lg)) - 3'd1;
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dsize_dec.sv
// ============================================================================
// Module   : dsize_dec
// Purpose  : Combinational DSIZE priority select and ISIZE decode from the
//            micro-op fields and the IRD latches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsize_dec
  import dpm_pkg::*;
(
  input  logic [1:0] dtype_h,
  input  logic [1:0] lit_h,
  input  logic       istrm_h,
  input  logic       long_lit_l,
  input  logic       msrc_xb_h,
  input  logic [1:0] dsize_lat_h,
  input  logic [1:0] disp_isize_h,
  output logic [1:0] code_h,
  output logic [1:0] isize_h
);

  logic w_force;
  logic w_unused_lit;

  // Only LIT bit 0 takes part in the force condition.
  assign w_unused_lit = lit_h[1];

  // An I-stream fetch through the XB without literal bit 0 forces the size
  // to follow the displacement ISIZE instead of the micro-op data type.
  assign w_force = msrc_xb_h & istrm_h & ~lit_h[0];

  // Size select in priority order: forced, long literal, latched, data type.
  always_comb begin
    code_h = SZ_BYTE;
    if (w_force) begin
      code_h = {&disp_isize_h, ~disp_isize_h[0]};
    end else if (!long_lit_l) begin
      code_h = SZ_LONG;
    end else if (dtype_h == 2'd3) begin
      code_h = dsize_lat_h;
    end else begin
      code_h = dtype_h;
    end
  end

  // ISIZE passes the displacement size through unless forced, where it is
  // rebuilt from the data type (or the latched size for type 3).
  always_comb begin
    isize_h = disp_isize_h;
    if (w_force) begin
      case (dtype_h)
        2'd0:    isize_h = 2'd1;
        2'd1:    isize_h = 2'd2;
        2'd2:    isize_h = 2'd3;
        default: isize_h = {dsize_lat_h != 2'd0, dsize_lat_h != 2'd1};
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/dsize_seq.sv
// ============================================================================
// Module   : dsize_seq
// Purpose  : Registered operand-size decode and multi-beat transfer sequencer.
//            Splits operands wider than the bus into aligned beats with a
//            beat handshake, flush, and back-to-back operand acceptance.
// Config   : DSEQ_ISTRM_CNT_EN - enables the saturating I-stream byte counter;
//            when undefined istrm_bytes_h is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsize_seq
  import dpm_pkg::*;
#(
  parameter int BUS_LG = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset_h,
  input  logic             uop_valid_h,
  output logic             ready_h,
  input  logic [1:0]       dtype_h,
  input  logic [1:0]       lit_h,
  input  logic             istrm_h,
  input  logic             long_lit_l,
  input  logic             msrc_xb_h,
  input  logic [1:0]       dsize_lat_h,
  input  logic [1:0]       disp_isize_h,
  input  logic             beat_ack_h,
  input  logic             flush_h,
  output logic             beat_valid_h,
  output logic [1:0]       dsize_h,
  output logic [1:0]       op_dsize_h,
  output logic [5:0]       byte_off_h,
  output logic             last_beat_h,
  output logic [1:0]       isize_l,
  output logic [CNT_W-1:0] istrm_bytes_h
);

  localparam logic [1:0] c_bus_lg    = 2'(BUS_LG);
  localparam logic [5:0] c_beat_step = 6'(1 << BUS_LG);

  dseq_state_t r_state;
  dseq_state_t w_state_nxt;

  logic [1:0]  w_code;
  logic [1:0]  w_isize;
  logic        w_kill;
  logic        w_accept;
  logic        w_step;

  logic [1:0]  r_dsize;
  logic [1:0]  r_op_dsize;
  logic [5:0]  r_byte_off;
  logic        r_last;
  logic [1:0]  r_isize;
  logic [2:0]  r_beat;
  logic [2:0]  r_beat_last;

  dsize_dec u_dec (
    .dtype_h      (dtype_h),
    .lit_h        (lit_h),
    .istrm_h      (istrm_h),
    .long_lit_l   (long_lit_l),
    .msrc_xb_h    (msrc_xb_h),
    .dsize_lat_h  (dsize_lat_h),
    .disp_isize_h (disp_isize_h),
    .code_h       (w_code),
    .isize_h      (w_isize)
  );

  // Reset and flush both abort the operand; flush just keeps the counter
  // semantics identical to reset.
  assign w_kill = reset_h | flush_h;

  // Next state, readiness and beat advance; a kill overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    ready_h     = 1'b0;
    w_step      = 1'b0;
    w_accept    = 1'b0;
    if (w_kill) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          ready_h = 1'b1;
          if (uop_valid_h) begin
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          if (beat_ack_h) begin
            if (r_last) begin
              // Final beat taken: a new operand may start in the same cycle.
              ready_h     = 1'b1;
              w_state_nxt = uop_valid_h ? RUN : IDLE;
            end else begin
              w_step = 1'b1;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
      w_accept = ready_h & uop_valid_h;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset_h) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Beat datapath: load the decode on accept, step the offset on each ack.
  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_dsize     <= SZ_BYTE;
      r_op_dsize  <= SZ_BYTE;
      r_byte_off  <= 6'd0;
      r_last      <= 1'b0;
      r_isize     <= 2'd0;
      r_beat      <= 3'd0;
      r_beat_last <= 3'd0;
    end else if (w_accept) begin
      r_dsize     <= clamp_size(w_code, c_bus_lg);
      r_op_dsize  <= w_code;
      r_byte_off  <= 6'd0;
      r_last      <= (last_beat_idx(w_code, c_bus_lg) == 3'd0);
      r_isize     <= w_isize;
      r_beat      <= 3'd0;
      r_beat_last <= last_beat_idx(w_code, c_bus_lg);
    end else if (w_step) begin
      r_byte_off  <= r_byte_off + c_beat_step;
      r_beat      <= r_beat + 3'd1;
      r_last      <= ((r_beat + 3'd1) == r_beat_last);
    end
  end

  assign beat_valid_h = (r_state == RUN);
  assign dsize_h      = r_dsize;
  assign op_dsize_h   = r_op_dsize;
  assign byte_off_h   = r_byte_off;
  assign last_beat_h  = r_last;
  assign isize_l      = ~r_isize;

`ifdef DSEQ_ISTRM_CNT_EN
  logic [CNT_W-1:0] r_istrm_cnt;
  logic [CNT_W:0]   w_cnt_sum;

  assign w_cnt_sum = {1'b0, r_istrm_cnt} + {{(CNT_W-1){1'b0}}, w_isize};

  // Saturating count of I-stream bytes over accepted micro-ops.
  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_istrm_cnt <= '0;
    end else if (w_accept && istrm_h) begin
      r_istrm_cnt <= w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
    end
  end

  assign istrm_bytes_h = r_istrm_cnt;
`else
  assign istrm_bytes_h = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dsize_seq.sv
// ============================================================================
// Module   : tb_dsize_seq
// Purpose  : Directed self-checking bench for dsize_seq. Two instances share
//            stimulus: one with a 4-byte bus, one with a 1-byte bus.
// Config   : DSEQ_ISTRM_CNT_EN - selects the expected I-stream counter value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dsize_seq;

  logic       clk = 1'b0;
  logic       reset_h, uop_valid_h, istrm_h, long_lit_l, msrc_xb_h;
  logic       beat_ack_h, flush_h;
  logic [1:0] dtype_h, lit_h, dsize_lat_h, disp_isize_h;

  logic       b2_ready, b2_valid, b2_last;
  logic [1:0] b2_dsize, b2_op, b2_isize_l;
  logic [5:0] b2_off;
  logic [7:0] b2_cnt;

  logic       b0_ready, b0_valid, b0_last;
  logic [1:0] b0_dsize, b0_op, b0_isize_l;
  logic [5:0] b0_off;
  logic [7:0] b0_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dsize_seq #(.BUS_LG(2), .CNT_W(8)) dut_b2 (
    .clk(clk), .reset_h(reset_h), .uop_valid_h(uop_valid_h), .ready_h(b2_ready),
    .dtype_h(dtype_h), .lit_h(lit_h), .istrm_h(istrm_h), .long_lit_l(long_lit_l),
    .msrc_xb_h(msrc_xb_h), .dsize_lat_h(dsize_lat_h), .disp_isize_h(disp_isize_h),
    .beat_ack_h(beat_ack_h), .flush_h(flush_h), .beat_valid_h(b2_valid),
    .dsize_h(b2_dsize), .op_dsize_h(b2_op), .byte_off_h(b2_off),
    .last_beat_h(b2_last), .isize_l(b2_isize_l), .istrm_bytes_h(b2_cnt)
  );

  dsize_seq #(.BUS_LG(0), .CNT_W(8)) dut_b0 (
    .clk(clk), .reset_h(reset_h), .uop_valid_h(uop_valid_h), .ready_h(b0_ready),
    .dtype_h(dtype_h), .lit_h(lit_h), .istrm_h(istrm_h), .long_lit_l(long_lit_l),
    .msrc_xb_h(msrc_xb_h), .dsize_lat_h(dsize_lat_h), .disp_isize_h(disp_isize_h),
    .beat_ack_h(beat_ack_h), .flush_h(flush_h), .beat_valid_h(b0_valid),
    .dsize_h(b0_dsize), .op_dsize_h(b0_op), .byte_off_h(b0_off),
    .last_beat_h(b0_last), .isize_l(b0_isize_l), .istrm_bytes_h(b0_cnt)
  );

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    uop_valid_h = 0; istrm_h = 0; long_lit_l = 1; msrc_xb_h = 0;
    beat_ack_h = 0; flush_h = 0; dtype_h = 0; lit_h = 0;
    dsize_lat_h = 0; disp_isize_h = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_h = 1;
    step();
    step();
    reset_h = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (b2_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", b2_valid); bad++; end
    total++; if (b2_isize_l !== 2'b11) begin $display("FAIL rst_isize_l: got %b want 11", b2_isize_l); bad++; end
    total++; if (b2_ready !== 1'b1) begin $display("FAIL rst_ready: got %b want 1", b2_ready); bad++; end
    total++; if (b2_cnt !== 8'd0) begin $display("FAIL rst_cnt: got %0d want 0", b2_cnt); bad++; end
    total++; if ({b2_dsize, b2_op, b2_off, b2_last} !== 11'd0) begin
      $display("FAIL rst_outputs: got dsize=%0d op=%0d off=%0d last=%b want all 0",
               b2_dsize, b2_op, b2_off, b2_last); bad++; end
    // An ack with no beat outstanding must be ignored.
    beat_ack_h = 1;
    step();
    beat_ack_h = 0;
    total++; if (b2_valid !== 1'b0 || b2_off !== 6'd0) begin
      $display("FAIL idle_ack: got valid=%b off=%0d want 0/0", b2_valid, b2_off); bad++; end
  endtask

  task automatic test_single_long();
    do_reset();
    dtype_h = 2; uop_valid_h = 1;
    step();
    uop_valid_h = 0;
    total++; if (b2_valid !== 1'b1) begin $display("FAIL long_valid: got %b want 1", b2_valid); bad++; end
    total++; if (b2_dsize !== 2'd2 || b2_off !== 6'd0 || b2_last !== 1'b1) begin
      $display("FAIL long_beat: got dsize=%0d off=%0d last=%b want 2/0/1", b2_dsize, b2_off, b2_last); bad++; end
    beat_ack_h = 1;
    step();
    beat_ack_h = 0;
    total++; if (b2_valid !== 1'b0) begin $display("FAIL long_done: got %b want 0", b2_valid); bad++; end
  endtask

  task automatic test_back_to_back();
    do_reset();
    dtype_h = 3; dsize_lat_h = 3; uop_valid_h = 1;
    step();
    uop_valid_h = 0;
    total++; if (b2_off !== 6'd0 || b2_last !== 1'b0 || b2_op !== 2'd3 || b2_dsize !== 2'd2) begin
      $display("FAIL quad_b0: got off=%0d last=%b op=%0d dsize=%0d want 0/0/3/2",
               b2_off, b2_last, b2_op, b2_dsize); bad++; end
    beat_ack_h = 1;
    #1;
    total++; if (b2_ready !== 1'b0) begin $display("FAIL quad_mid_ready: got %b want 0", b2_ready); bad++; end
    step();
    total++; if (b2_off !== 6'd4 || b2_last !== 1'b1 || b2_valid !== 1'b1) begin
      $display("FAIL quad_b1: got off=%0d last=%b valid=%b want 4/1/1", b2_off, b2_last, b2_valid); bad++; end
    dtype_h = 2; uop_valid_h = 1;
    #1;
    total++; if (b2_ready !== 1'b1) begin $display("FAIL b2b_ready: got %b want 1", b2_ready); bad++; end
    step();
    uop_valid_h = 0; beat_ack_h = 0;
    total++; if (b2_valid !== 1'b1 || b2_op !== 2'd2 || b2_off !== 6'd0 || b2_last !== 1'b1) begin
      $display("FAIL b2b_next: got valid=%b op=%0d off=%0d last=%b want 1/2/0/1",
               b2_valid, b2_op, b2_off, b2_last); bad++; end
  endtask

  task automatic test_narrow_quad();
    do_reset();
    dtype_h = 3; dsize_lat_h = 3; uop_valid_h = 1;
    step();
    uop_valid_h = 0;
    for (int k = 0; k < 8; k++) begin
      total++; if (b0_valid !== 1'b1 || b0_off !== 6'(k) || b0_last !== (k == 7) || b0_dsize !== 2'd0) begin
        $display("FAIL narrow_beat%0d: got valid=%b off=%0d last=%b dsize=%0d want 1/%0d/%b/0",
                 k, b0_valid, b0_off, b0_last, b0_dsize, k, (k == 7)); bad++; end
      beat_ack_h = 1;
      step();
      beat_ack_h = 0;
    end
    total++; if (b0_valid !== 1'b0) begin $display("FAIL narrow_done: got %b want 0", b0_valid); bad++; end
  endtask

  task automatic test_flush();
    do_reset();
    dtype_h = 3; dsize_lat_h = 3; disp_isize_h = 1; uop_valid_h = 1;
    step();
    uop_valid_h = 0;
    for (int k = 0; k < 4; k++) begin
      beat_ack_h = 1;
      step();
    end
    beat_ack_h = 0;
    total++; if (b0_off !== 6'd4 || b0_valid !== 1'b1) begin
      $display("FAIL pre_flush: got off=%0d valid=%b want 4/1", b0_off, b0_valid); bad++; end
    flush_h = 1; uop_valid_h = 1; beat_ack_h = 1;
    #1;
    total++; if (b2_ready !== 1'b0) begin $display("FAIL flush_ready: got %b want 0", b2_ready); bad++; end
    step();
    flush_h = 0; uop_valid_h = 0; beat_ack_h = 0;
    total++; if (b0_valid !== 1'b0 || b2_valid !== 1'b0) begin
      $display("FAIL flush_valid: got b0=%b b2=%b want 0/0", b0_valid, b2_valid); bad++; end
    total++; if ({b0_dsize, b0_op, b0_off, b0_last} !== 11'd0 || b0_isize_l !== 2'b11) begin
      $display("FAIL flush_outputs: got dsize=%0d op=%0d off=%0d last=%b isize_l=%b want 0/0/0/0/11",
               b0_dsize, b0_op, b0_off, b0_last, b0_isize_l); bad++; end
  endtask

  task automatic test_force_isize();
    logic [7:0] exp_cnt;
    do_reset();
    msrc_xb_h = 1; istrm_h = 1; lit_h = 2'b10; dtype_h = 1; disp_isize_h = 3;
    uop_valid_h = 1;
    step();
    uop_valid_h = 0;
    total++; if (b2_op !== 2'd2 || b2_isize_l !== 2'b01) begin
      $display("FAIL force_decode: got op=%0d isize_l=%b want 2/01", b2_op, b2_isize_l); bad++; end
`ifdef DSEQ_ISTRM_CNT_EN
    exp_cnt = 8'd2;
`else
    exp_cnt = 8'd0;
`endif
    total++; if (b2_cnt !== exp_cnt) begin $display("FAIL cnt_first: got %0d want %0d", b2_cnt, exp_cnt); bad++; end
    // 199 more back-to-back single-beat uops, each adding ISIZE=2.
    uop_valid_h = 1; beat_ack_h = 1;
    for (int i = 0; i < 199; i++) step();
    uop_valid_h = 0; beat_ack_h = 0;
`ifdef DSEQ_ISTRM_CNT_EN
    exp_cnt = 8'd255;
`else
    exp_cnt = 8'd0;
`endif
    total++; if (b2_cnt !== exp_cnt) begin $display("FAIL cnt_sat: got %0d want %0d", b2_cnt, exp_cnt); bad++; end
  endtask

  task automatic test_long_lit_hold();
    do_reset();
    dtype_h = 0; long_lit_l = 0; disp_isize_h = 1; uop_valid_h = 1;
    step();
    uop_valid_h = 0; long_lit_l = 1; dtype_h = 3; disp_isize_h = 2;
    for (int c = 0; c < 3; c++) begin
      total++; if (b2_valid !== 1'b1 || b2_op !== 2'd2 || b2_dsize !== 2'd2 || b2_off !== 6'd0 ||
                   b2_last !== 1'b1 || b2_isize_l !== 2'b10) begin
        $display("FAIL lit_hold%0d: got valid=%b op=%0d dsize=%0d off=%0d last=%b isize_l=%b want 1/2/2/0/1/10",
                 c, b2_valid, b2_op, b2_dsize, b2_off, b2_last, b2_isize_l); bad++; end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_long();
    test_back_to_back();
    test_narrow_quad();
    test_flush();
    test_force_isize();
    test_long_lit_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dsize_seq.md
# dsize_seq

Registered operand-size decode and multi-beat transfer sequencer for the DPM data path. Per accepted microcycle it resolves DSIZE and ISIZE from the micro-op fields and IRD latches, and splits operands wider than the bus into aligned beats. Generalised in bus width and adds quadword support, beat handshake, flush, and an optional I-stream byte counter. Sits between the micro-op field latches and the bus/MDR control.

## Interface
- BUS_LG, default 2: log2 of bus width in bytes. Legal range 0..3.
- CNT_W, default 8: width of the I-stream byte counter.

- clk: input, 1 bit. Microcycle clock.
- reset_h: input, 1 bit. Synchronous reset, active high.
- uop_valid_h: input, 1 bit. Micro-op fields are valid this cycle.
- ready_h: output, 1 bit. Sequencer accepts a micro-op this cycle.
- dtype_h: input, 2 bits. DTYPE micro-op field.
- lit_h: input, 2 bits. LIT micro-op field.
- istrm_h: input, 1 bit. ISTRM micro-op field.
- long_lit_l: input, 1 bit. LONG LIT order, active low.
- msrc_xb_h: input, 1 bit. MSRC XB from MIC.
- dsize_lat_h: input, 2 bits. Latched DSIZE from IRD; code 3 means quadword.
- disp_isize_h: input, 2 bits. DISP ISIZE from IRD.
- beat_ack_h: input, 1 bit. Consumer took the current beat.
- flush_h: input, 1 bit. Synchronous abort.
- beat_valid_h: output, 1 bit. Beat outputs are valid.
- dsize_h: output, 2 bits. Per-beat size code, clamped to BUS_LG.
- op_dsize_h: output, 2 bits. Full operand size code.
- byte_off_h: output, 6 bits. Byte offset of the current beat.
- last_beat_h: output, 1 bit. Current beat is the final beat.
- isize_l: output, 2 bits. Registered ISIZE, active low.
- istrm_bytes_h: output, CNT_W bits. I-stream byte count.

## Operation
- Force condition: force = msrc_xb_h & istrm_h & ~lit_h[0].
- Size select, in priority order:
  - force: derive from ISIZE: disp 0→1, 1→0, 2→1, 3→2. This is {&disp_isize_h, ~disp_isize_h[0]}.
  - else if long_lit_l = 0: longword, code 2.
  - else if dtype_h = 3: dsize_lat_h.
  - else: dtype_h.
- Size codes: 0 byte, 1 word, 2 long, 3 quad. Operand byte count = 2^code.
- ISIZE:
  - ~force: ISIZE = disp_isize_h.
  - force with dtype 0/1/2: ISIZE = 1/2/3.
  - force with dtype 3: ISIZE = {dsize_lat_h≠0, dsize_lat_h≠1}.
  - isize_l = ~ISIZE.
- Beat count: nbeats = 2^(code−BUS_LG) if code > BUS_LG, else 1.
  - Beat k: dsize_h = min(code, BUS_LG); byte_off_h = k·2^BUS_LG.
  - last_beat_h = (k = nbeats−1).
- FSM states:
  - IDLE: ready_h = 1, beat_valid_h = 0.
    - uop_valid_h captures the decode and sets k = 0, then → RUN.
  - RUN: beat_valid_h = 1.
    - beat_ack_h with ~last: k+1.
    - beat_ack_h with last: → IDLE, unless a new uop is accepted in the same cycle, in which case stay in RUN with k = 0.
- Ready: ready_h = IDLE | (RUN & last_beat_h & beat_ack_h). This allows back-to-back operands with no bubble.
- flush_h has highest priority:
  - next state is IDLE, k = 0, and the pending beats are dropped.
  - uop_valid_h is ignored in that cycle, and ready_h = 0.
- reset_h behaves identically to flush_h, and also clears the registered decode.

## Timing
- Decode latency is 1 cycle: a uop accepted at edge N presents beat 0 after edge N.
- dsize_h, op_dsize_h, byte_off_h, last_beat_h and isize_l are registered. They hold stable while beat_valid_h & ~beat_ack_h.
- ready_h is combinational from state, last_beat_h and beat_ack_h.
- Reset values:
  - state IDLE; beat_valid_h = 0.
  - dsize_h = 0, op_dsize_h = 0, byte_off_h = 0, last_beat_h = 0.
  - isize_l = 2'b11; istrm_bytes_h = 0.
- beat_ack_h while beat_valid_h = 0 is ignored.
- Reset or flush mid-operand: the outputs return to their reset values on the next cycle.

## Configuration
- Macro DSEQ_ISTRM_CNT_EN.
- Defined:
  - istrm_bytes_h adds ISIZE on every accepted uop with istrm_h = 1.
  - The counter saturates at 2^CNT_W−1.
  - It is cleared by reset_h or flush_h; flush wins over add.
- Undefined: there is no counter logic, and istrm_bytes_h is tied to 0.

## Structure
- Package dpm_pkg holds:
  - size code constants SZ_BYTE, SZ_WORD, SZ_LONG, SZ_QUAD;
  - the FSM state enum dseq_state_t (IDLE, RUN).
- Sub-module dsize_dec: purely combinational size select and ISIZE decode. The top level holds the registers, FSM and counter.

## Test plan
- Reset: assert reset_h for 2 cycles → beat_valid_h = 0, isize_l = 2'b11, ready_h = 1, istrm_bytes_h = 0.
- dtype = 2, long_lit_l = 1, BUS_LG = 2 → one beat with dsize_h = 2, byte_off_h = 0, last_beat_h = 1.
- dtype = 3, dsize_lat_h = 3, BUS_LG = 2:
  - beat 0: byte_off = 0, last = 0; beat 1: byte_off = 4, last = 1.
  - A second uop offered with the last ack is accepted with no bubble.
- Quad with BUS_LG = 0 → 8 beats, byte_off_h = 0..7.
  - flush_h after beat 3 → IDLE next cycle, outputs at reset values.
- msrc_xb = 1, istrm = 1, lit[0] = 0, dtype = 1, disp_isize = 3 → op_dsize_h = 2, isize_l = 2'b01.
  - With DSEQ_ISTRM_CNT_EN, after 200 such uops istrm_bytes_h = 255, saturated.
- long_lit_l = 0 with dtype = 0 → op_dsize_h = 2.
  - beat_ack_h held low for 3 cycles → outputs stable for those 3 cycles.
